// File: rtl/sp_layer_serial.sv
// Serial substitution/permutation stage for a 64-bit PRESENT-style round:
// one nibble per cycle through an external 4-bit SBox, then the pLayer bit shuffle.
module sp_layer_serial #(
  parameter int STATE_W = 64,
  parameter int NIBBLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic [3:0]         sbox_in,
  input  logic [3:0]         sbox_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_PERM,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [STATE_W-1:0] st_q, st_d;

  // Bit 4k+j lands on bit (STATE_W/4)*j + k, which equals (16*i) mod 63 with bit 63 fixed.
  function automatic logic [STATE_W-1:0] p_layer(input logic [STATE_W-1:0] x);
    logic [STATE_W-1:0] y;
    y = '0;
    for (int i = 0; i < STATE_W; i++) begin
      y[(i % 4) * (STATE_W / 4) + i / 4] = x[i];
    end
    return y;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      st_q    <= st_d;
    end
  end

  // NOTE: each combinational block assigns a default first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_SUB;
      S_SUB:   if (idx_q == LAST_IDX) state_d = S_PERM;
      S_PERM:  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // sbox_out is only consumed in SUB, so an undriven SBox elsewhere cannot pollute st.
  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d  = in_state;
          idx_d = '0;
        end
      end
      S_SUB: begin
        st_d[{idx_q, 2'b00} +: 4] = sbox_out;
        idx_d                     = idx_q + 1'b1;
      end
      S_PERM:  st_d = p_layer(st_q);
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    out_state = (state_q == S_DONE) ? st_q : '0;
    sbox_in   = (state_q == S_SUB) ? st_q[{idx_q, 2'b00} +: 4] : 4'h0;
  end

endmodule
